bitcnt_seq_miter: RTL and testbench

//  Clocked, streaming equivalence checker for mutation runs on bitcnt. Each accepted operand is fed
//  to a reference core (mutsel=0) and a unit-under-test core (mutsel=uut_mutsel), both pipelined.
//  The two results are compared with per-opcode width masking. Mismatches are counted, and the

---
 rtl/bitcnt_pkg.sv | 36 +++
 rtl/bitcnt_seq_miter_pipe.sv | 78 +++++++
 rtl/bitcnt_seq_miter.sv | 135 +++++++++++++
 tb/tb_bitcnt_seq_miter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitcnt_pkg.sv
// Shared opcode encodings, result-compare mask and pipeline tag type for the bitcnt
// streaming miter and its core pipelines.
package bitcnt_pkg;

    // Widest datapath the compare mask can describe.
    localparam int MAX_XLEN = 256;

    localparam logic [2:0] FUNC_CPOP       = 3'b000;
    localparam logic [2:0] FUNC_CLZ        = 3'b010;
    localparam logic [2:0] FUNC_CTZ        = 3'b100;
    localparam logic [2:0] FUNC_UNUSED_MSK = 3'b110;
    localparam int         FUNC_HALF_BIT   = 0;

    typedef struct packed {
        logic       valid;
        logic [2:0] func;
        logic       mutsel;
    } chk_tag_t;

    function automatic logic func_checked(input logic [2:0] func);
        return (func & FUNC_UNUSED_MSK) != FUNC_UNUSED_MSK;
    endfunction

    // Bits of the result that are meaningful for this opcode (low half for "w" ops).
    function automatic logic [MAX_XLEN-1:0] cmp_mask(input logic [2:0] func, input int xlen);
        logic [MAX_XLEN-1:0] m;
        int width;
        width = func[FUNC_HALF_BIT] ? xlen / 2 : xlen;
        m = '0;
        for (int i = 0; i < MAX_XLEN; i++) begin
            m[i] = (i < width);
        end
        return m;
    endfunction

endpackage

// File: rtl/bitcnt_seq_miter_pipe.sv
// Combinational bit-count core (cpop/clz/ctz, full or low-half) followed by LATENCY
// result registers. mutsel=1 selects a mutant that flips the result MSB.
module bitcnt_pipe
    import bitcnt_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int LATENCY = 2
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            mutsel,
    input  logic [XLEN-1:0] din,
    input  logic [2:0]      func,
    output logic [XLEN-1:0] dout
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    logic [XLEN-1:0] src;
    logic [CW-1:0]   pop_cnt;
    logic [CW-1:0]   lz_cnt;
    logic [CW-1:0]   tz_cnt;
    logic [CW-1:0]   cnt;
    logic            lz_done;
    logic            tz_done;
    logic [XLEN-1:0] core_res;
    int              width;

    always_comb begin
        width   = func[FUNC_HALF_BIT] ? HALF : XLEN;
        src     = func[FUNC_HALF_BIT] ? {{(XLEN-HALF){1'b0}}, din[HALF-1:0]} : din;
        pop_cnt = '0;
        lz_cnt  = '0;
        tz_cnt  = '0;
        lz_done = 1'b0;
        tz_done = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            pop_cnt = pop_cnt + CW'(src[i]);
        end
        // Scan only the active width so an all-zero operand counts to that width.
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (i < width && !lz_done) begin
                if (src[i]) lz_done = 1'b1;
                else        lz_cnt  = lz_cnt + CW'(1);
            end
        end
        for (int i = 0; i < XLEN; i++) begin
            if (i < width && !tz_done) begin
                if (src[i]) tz_done = 1'b1;
                else        tz_cnt  = tz_cnt + CW'(1);
            end
        end
        case (func[2:1])
            2'b00:   cnt = pop_cnt;
            2'b01:   cnt = lz_cnt;
            2'b10:   cnt = tz_cnt;
            default: cnt = '0;
        endcase
        core_res         = '0;
        core_res[CW-1:0] = cnt;
        if (mutsel) core_res[XLEN-1] = ~core_res[XLEN-1];
    end

    logic [XLEN-1:0] stage_q [LATENCY];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= core_res;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[LATENCY-1];

endmodule

// File: rtl/bitcnt_seq_miter.sv
// Streaming miter: reference and mutant bitcnt pipelines fed the same operand stream,
// results compared under a per-opcode mask, mismatches counted and the first captured.
module bitcnt_seq_miter
    import bitcnt_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int LATENCY      = 2,
    parameter int CNT_W        = 16,
    parameter bit HALT_ON_FAIL = 1'b0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             uut_mutsel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func,
    input  logic [XLEN-1:0]  in_data,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic             fail,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       fail_func,
    output logic [XLEN-1:0]  fail_ref,
    output logic [XLEN-1:0]  fail_uut,
    output logic [CNT_W-1:0] fail_index
);

    // Handshake: an operand transfers on a rising edge where in_valid && in_ready; the
    // producer holds in_func/in_data stable while in_valid is high. Results have no
    // backpressure: chk_valid is a one-cycle strobe that must be consumed when seen.
    logic ready_en;
    logic accept;

    assign in_ready = ready_en & ~(HALT_ON_FAIL & fail);
    assign accept   = in_valid & in_ready;

    logic [XLEN-1:0] ref_res;
    logic [XLEN-1:0] uut_res;

    bitcnt_pipe #(.XLEN(XLEN), .LATENCY(LATENCY)) u_ref (
        .clock  (clock),
        .resetn (resetn),
        .mutsel (1'b0),
        .din    (in_data),
        .func   (in_func),
        .dout   (ref_res)
    );

    bitcnt_pipe #(.XLEN(XLEN), .LATENCY(LATENCY)) u_uut (
        .clock  (clock),
        .resetn (resetn),
        .mutsel (uut_mutsel),
        .din    (in_data),
        .func   (in_func),
        .dout   (uut_res)
    );

    chk_tag_t tag_q [LATENCY];
    chk_tag_t tag_out;
    logic [MAX_XLEN-1:0] diff_ext;
    logic checked;
    logic mismatch;
    logic unused_tag_mutsel;

    assign tag_out           = tag_q[LATENCY-1];
    assign unused_tag_mutsel = tag_out.mutsel;

    always_comb begin
        diff_ext             = '0;
        diff_ext[XLEN-1:0]   = ref_res ^ uut_res;
    end

    assign checked  = tag_out.valid && func_checked(tag_out.func);
    assign mismatch = checked && (|(diff_ext & cmp_mask(tag_out.func, XLEN)));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_en   <= 1'b0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            fail       <= 1'b0;
            chk_count  <= '0;
            err_count  <= '0;
            fail_func  <= '0;
            fail_ref   <= '0;
            fail_uut   <= '0;
            fail_index <= '0;
        end else begin
            ready_en        <= 1'b1;
            tag_q[0].valid  <= accept;
            tag_q[0].func   <= in_func;
            tag_q[0].mutsel <= uut_mutsel;
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];

            // clear wins: the result leaving the pipe this cycle is dropped entirely.
            if (clear) begin
                chk_valid  <= 1'b0;
                chk_pass   <= 1'b0;
                fail       <= 1'b0;
                chk_count  <= '0;
                err_count  <= '0;
                fail_func  <= '0;
                fail_ref   <= '0;
                fail_uut   <= '0;
                fail_index <= '0;
            end else begin
                chk_valid <= tag_out.valid;
                chk_pass  <= tag_out.valid && !mismatch;
                if (checked) begin
                    chk_count <= (&chk_count) ? chk_count : chk_count + CNT_W'(1);
                    if (mismatch) begin
                        err_count <= (&err_count) ? err_count : err_count + CNT_W'(1);
                        if (!fail) begin
                            fail       <= 1'b1;
                            fail_func  <= tag_out.func;
                            fail_ref   <= ref_res;
                            fail_uut   <= uut_res;
                            fail_index <= chk_count;
                        end
                    end
                end
            end
        end
    end

`ifdef FORMAL
    always @(posedge clock) begin
        if (resetn) assert (!(chk_valid && !chk_pass));
    end
`endif

endmodule

// File: tb/tb_bitcnt_seq_miter.sv
// Directed scoreboard bench for bitcnt_seq_miter: a free-running instance and a
// halt-on-fail instance share clock and reset; monitors pop expected chk_pass values.
module tb_bitcnt_seq_miter;
    import bitcnt_pkg::*;

    localparam int XLEN = 64;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    // ---------------- main instance (CNT_W=4, no halt) ----------------
    logic            clear, uut_mutsel, in_valid, in_ready;
    logic [2:0]      in_func;
    logic [XLEN-1:0] in_data;
    logic            chk_valid, chk_pass, fail;
    logic [3:0]      chk_count, err_count, fail_index;
    logic [2:0]      fail_func;
    logic [XLEN-1:0] fail_ref, fail_uut;

    bitcnt_seq_miter #(.XLEN(XLEN), .LATENCY(2), .CNT_W(4), .HALT_ON_FAIL(1'b0)) dut (
        .clock(clock), .resetn(resetn), .clear(clear), .uut_mutsel(uut_mutsel),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func), .in_data(in_data),
        .chk_valid(chk_valid), .chk_pass(chk_pass), .fail(fail),
        .chk_count(chk_count), .err_count(err_count), .fail_func(fail_func),
        .fail_ref(fail_ref), .fail_uut(fail_uut), .fail_index(fail_index)
    );

    // ---------------- halt-on-fail instance ----------------
    logic            h_clear, h_mutsel, h_valid, h_ready;
    logic [2:0]      h_func;
    logic [XLEN-1:0] h_data;
    logic            h_chk_valid, h_chk_pass, h_fail;
    logic [15:0]     h_chk_count, h_err_count, h_fail_index;
    logic [2:0]      h_fail_func;
    logic [XLEN-1:0] h_fail_ref, h_fail_uut;

    bitcnt_seq_miter #(.XLEN(XLEN), .LATENCY(2), .CNT_W(16), .HALT_ON_FAIL(1'b1)) dut_h (
        .clock(clock), .resetn(resetn), .clear(h_clear), .uut_mutsel(h_mutsel),
        .in_valid(h_valid), .in_ready(h_ready), .in_func(h_func), .in_data(h_data),
        .chk_valid(h_chk_valid), .chk_pass(h_chk_pass), .fail(h_fail),
        .chk_count(h_chk_count), .err_count(h_err_count), .fail_func(h_fail_func),
        .fail_ref(h_fail_ref), .fail_uut(h_fail_uut), .fail_index(h_fail_index)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [0:0] exp_q[$];
    logic [0:0] exp_h_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The mutant flips only the result MSB, so only checked full-width ops can differ.
    function automatic logic model_pass(input logic [2:0] f, input logic m);
        return !(m && f[2:1] != 2'b11 && !f[FUNC_HALF_BIT]);
    endfunction

    always @(negedge clock) begin
        if (resetn && chk_valid) begin
            if (exp_q.size() == 0) check("spurious_chk_valid", {63'b0, chk_valid}, 64'd0);
            else check("chk_pass", {63'b0, chk_pass}, {63'b0, exp_q.pop_front()});
        end
        if (resetn && h_chk_valid) begin
            if (exp_h_q.size() == 0) check("h_spurious_chk_valid", {63'b0, h_chk_valid}, 64'd0);
            else check("h_chk_pass", {63'b0, h_chk_pass}, {63'b0, exp_h_q.pop_front()});
        end
    end

    // ---------------- driver tasks (enter and leave on a falling edge) ----------------
    task automatic drive(input logic [2:0] f, input logic [63:0] d, input logic m, input logic push);
        in_valid   = 1'b1;
        in_func    = f;
        in_data    = d;
        uut_mutsel = m;
        if (push) exp_q.push_back(model_pass(f, m));
    endtask

    task automatic send(input logic [2:0] f, input logic [63:0] d, input logic m, input logic push);
        drive(f, d, m, push);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic pattern_run(input logic [7:0] issue, output logic [7:0] hist);
        hist = '0;
        for (int i = 0; i < 8; i++) begin
            hist[i] = chk_valid;
            if (issue[i]) drive(FUNC_CPOP, 64'hF, 1'b0, 1'b1);
            else in_valid = 1'b0;
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    logic [2:0]  vec_func [12];
    logic [63:0] vec_data [12];
    logic [7:0]  hist;

    initial begin
        clear = 0; uut_mutsel = 0; in_valid = 0; in_func = 0; in_data = 0;
        h_clear = 0; h_mutsel = 0; h_valid = 0; h_func = 0; h_data = 0;

        vec_func = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101,
                     3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b100};
        vec_data = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                     64'h0000_0001_0000_0000, 64'h0, 64'h0000_0000_8000_0000,
                     64'hDEAD_BEEF_0123_4567, 64'h1, 64'hA5A5_5A5A_F0F0_0F0F,
                     64'h0123_4567_89AB_CDEF, 64'h1, 64'h8000_0000_0000_0000};

        // 1. reset state and reset mid-stream
        repeat (3) @(negedge clock);
        check("ready_in_reset", {63'b0, in_ready}, 64'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("ready_after_reset", {63'b0, in_ready}, 64'd1);
        check("chk_count_reset", chk_count, 64'd0);
        check("err_count_reset", err_count, 64'd0);
        check("fail_reset", {63'b0, fail}, 64'd0);
        send(FUNC_CPOP, 64'h3, 1'b0, 1'b1);   // reaches the output just before reset
        send(FUNC_CPOP, 64'h7, 1'b0, 1'b0);
        send(FUNC_CPOP, 64'hF, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        check("ready_after_midreset", {63'b0, in_ready}, 64'd1);
        idle(5);
        check("chk_count_midreset", chk_count, 64'd0);
        check("err_count_midreset", err_count, 64'd0);

        // 2. self-check across all opcodes
        clear_pulse();
        for (int i = 0; i < 12; i++) send(vec_func[i], vec_data[i], 1'b0, 1'b1);
        idle(4);
        check("self_chk_count", chk_count, 64'd10);
        check("self_err_count", err_count, 64'd0);
        check("self_fail", {63'b0, fail}, 64'd0);

        // 3. latency and throughput
        pattern_run(8'b0000_0001, hist);
        check("latency_single", hist, 64'h08);
        idle(3);
        pattern_run(8'b0000_1111, hist);
        check("latency_b2b", hist, 64'h78);
        idle(3);

        // 4. mutation: half ops and unchecked op pass, full op fails
        clear_pulse();
        send(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send(3'b011, 64'h0000_0000_0000_00F0, 1'b1, 1'b1);
        send(3'b101, 64'h0000_0000_0000_0100, 1'b1, 1'b1);
        send(3'b110, 64'h1234, 1'b1, 1'b1);
        send(3'b000, 64'h0000_0000_0000_00FF, 1'b1, 1'b1);
        idle(4);
        check("mut_fail", {63'b0, fail}, 64'd1);
        check("mut_err_count", err_count, 64'd1);
        check("mut_chk_count", chk_count, 64'd4);
        check("mut_fail_func", fail_func, 64'd0);
        check("mut_fail_index", fail_index, 64'd3);
        check("mut_fail_ref", fail_ref, 64'd8);
        check("mut_fail_uut", fail_uut, 64'h8000_0000_0000_0008);

        // 5. saturation, capture hold, clear racing a failure
        for (int i = 0; i < 20; i++) send(3'b010, 64'h1 << (i % 8), 1'b1, 1'b1);
        idle(4);
        check("sat_err_count", err_count, 64'd15);
        check("sat_chk_count", chk_count, 64'd15);
        check("hold_fail_func", fail_func, 64'd0);
        check("hold_fail_index", fail_index, 64'd3);
        check("hold_fail_ref", fail_ref, 64'd8);
        drive(3'b000, 64'hFFFF, 1'b1, 1'b0);   // leaves the pipe in the clear cycle
        @(negedge clock);
        drive(3'b100, 64'h10, 1'b1, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        idle(4);
        check("clr_chk_count", chk_count, 64'd1);
        check("clr_err_count", err_count, 64'd1);
        check("clr_fail", {63'b0, fail}, 64'd1);
        check("clr_fail_func", fail_func, 64'd4);
        check("clr_fail_index", fail_index, 64'd0);
        check("clr_fail_ref", fail_ref, 64'd4);
        check("clr_fail_uut", fail_uut, 64'h8000_0000_0000_0004);

        // 6. halt on fail: two in-flight ops drain, then ready stays low until clear
        hist = '0;
        for (int i = 0; i < 8; i++) begin
            hist[i] = h_ready;
            if (h_ready) begin
                h_valid = 1'b1; h_func = 3'b000; h_data = 64'hFF; h_mutsel = 1'b1;
                exp_h_q.push_back(1'b0);
            end else begin
                h_valid = 1'b0;
            end
            @(negedge clock);
        end
        h_valid = 1'b0;
        check("halt_ready_hist", hist, 64'h07);
        repeat (4) @(negedge clock);
        check("halt_chk_count", h_chk_count, 64'd3);
        check("halt_err_count", h_err_count, 64'd3);
        check("halt_fail_index", h_fail_index, 64'd0);
        check("halt_ready_low", {63'b0, h_ready}, 64'd0);
        h_clear = 1'b1;
        @(negedge clock);
        h_clear = 1'b0;
        check("halt_ready_after_clear", {63'b0, h_ready}, 64'd1);
        check("halt_fail_after_clear", {63'b0, h_fail}, 64'd0);

        idle(2);
        check("exp_q_drained", exp_q.size(), 64'd0);
        check("exp_h_q_drained", exp_h_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
